// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter for the loader (L), data (D) and
// instruction (I) ports. L has absolute priority and can lock out the core.
// D and I share the remaining slots round-robin. Grants are combinational,
// and responses come back exactly one cycle after the grant.
module mem_arbiter #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int          MEM_SIZE     = 16384,
  parameter int          AW           = $clog2(MEM_SIZE / 4)
) (
  input  logic          clk,
  input  logic          rst_n,

  // instruction port (read only)
  input  logic          i_req_i,
  input  logic [31:0]   i_addr_i,
  output logic          i_gnt_o,
  output logic          i_rvalid_o,
  output logic [31:0]   i_rdata_o,
  output logic          i_err_o,

  // data port
  input  logic          d_req_i,
  input  logic [31:0]   d_addr_i,
  input  logic          d_we_i,
  input  logic [3:0]    d_be_i,
  input  logic [31:0]   d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [31:0]   d_rdata_o,
  output logic          d_err_o,

  // boot-loader port
  input  logic          l_req_i,
  input  logic [31:0]   l_addr_i,
  input  logic          l_we_i,
  input  logic [3:0]    l_be_i,
  input  logic [31:0]   l_wdata_i,
  input  logic          l_lock_i,
  output logic          l_gnt_o,
  output logic          l_rvalid_o,
  output logic [31:0]   l_rdata_o,
  output logic          l_err_o,

  // RAM side
  output logic          mem_en_o,
  output logic [3:0]    mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  // Upper bound of the window as a 32-bit quantity so the range compare is
  // done unsigned at full address width.
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2,
    OWN_L    = 2'd3
  } owner_t;

  // Arbitration state and response stage
  logic   last_owner_d;   // 1: D held the last core grant, 0: I did
  owner_t winner;
  owner_t resp_owner;
  logic   resp_err;
  logic   resp_read;

  // Offsets into the RAM window; subtraction wraps, so addresses below the
  // base land far above MEM_LIMIT and are caught by the same compare.
  logic [31:0] i_off;
  logic [31:0] d_off;
  logic [31:0] l_off;

  assign i_off = i_addr_i - BOOT_ADDRESS;
  assign d_off = d_addr_i - BOOT_ADDRESS;
  assign l_off = l_addr_i - BOOT_ADDRESS;

  // Payload of the winning requester
  logic        sel_in_range;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_off;
  logic [31:0] sel_wdata;
  logic        granted;
  logic        access;

  // Winner selection: L first, then D/I round-robin unless locked out.
  // Grants are suppressed while reset is held so every output reads 0.
  always_comb begin
    winner = OWN_NONE;
    if (!rst_n) begin
      winner = OWN_NONE;
    end else if (l_req_i) begin
      winner = OWN_L;
    end else if (!l_lock_i) begin
      if (d_req_i && i_req_i) begin
        winner = last_owner_d ? OWN_I : OWN_D;
      end else if (d_req_i) begin
        winner = OWN_D;
      end else if (i_req_i) begin
        winner = OWN_I;
      end
    end
  end

  assign l_gnt_o = (winner == OWN_L);
  assign d_gnt_o = (winner == OWN_D);
  assign i_gnt_o = (winner == OWN_I);
  assign granted = (winner != OWN_NONE);

  // Route the winner's address and write payload toward the RAM.
  always_comb begin
    sel_off   = 32'd0;
    sel_we    = 1'b0;
    sel_be    = 4'b0000;
    sel_wdata = 32'd0;
    case (winner)
      OWN_L: begin
        sel_off   = l_off;
        sel_we    = l_we_i;
        sel_be    = l_be_i;
        sel_wdata = l_wdata_i;
      end
      OWN_D: begin
        sel_off   = d_off;
        sel_we    = d_we_i;
        sel_be    = d_be_i;
        sel_wdata = d_wdata_i;
      end
      OWN_I: begin
        // the instruction port is read only
        sel_off   = i_off;
        sel_we    = 1'b0;
        sel_be    = 4'b0000;
        sel_wdata = 32'd0;
      end
      default: begin
        sel_off   = 32'd0;
        sel_we    = 1'b0;
        sel_be    = 4'b0000;
        sel_wdata = 32'd0;
      end
    endcase
  end

  assign sel_in_range = (sel_off < MEM_LIMIT);
  assign access       = granted && sel_in_range;

  // Drive the RAM only for granted in-range accesses; out-of-range ones
  // leave it idle and complete with an error response instead.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = 32'd0;
    if (access) begin
      mem_en_o    = 1'b1;
      mem_we_o    = sel_we ? sel_be : 4'b0000;
      mem_addr_o  = sel_off[AW+1:2];
      mem_wdata_o = sel_wdata;
    end
  end

  // Offset bits below the word index and above the window are ignored by
  // the RAM address; fold them here so they are visibly consumed.
  logic unused_off_bits;
  assign unused_off_bits = ^sel_off;

  // Round-robin pointer: remembers which core port was served last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_d <= 1'b0;
    end else if (winner == OWN_D) begin
      last_owner_d <= 1'b1;
    end else if (winner == OWN_I) begin
      last_owner_d <= 1'b0;
    end
  end

  // Response stage: captures who was granted and how the access completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_owner <= OWN_NONE;
      resp_err   <= 1'b0;
      resp_read  <= 1'b0;
    end else begin
      resp_owner <= winner;
      resp_err   <= granted && !sel_in_range;
      resp_read  <= access && !sel_we;
    end
  end

  // Read data is only forwarded for in-range reads; writes and errors
  // return zero.
  logic [31:0] resp_data;
  assign resp_data = resp_read ? mem_rdata_i : 32'd0;

  assign i_rvalid_o = (resp_owner == OWN_I);
  assign d_rvalid_o = (resp_owner == OWN_D);
  assign l_rvalid_o = (resp_owner == OWN_L);

  assign i_rdata_o  = i_rvalid_o ? resp_data : 32'd0;
  assign d_rdata_o  = d_rvalid_o ? resp_data : 32'd0;
  assign l_rdata_o  = l_rvalid_o ? resp_data : 32'd0;

  assign i_err_o    = i_rvalid_o && resp_err;
  assign d_err_o    = d_rvalid_o && resp_err;
  assign l_err_o    = l_rvalid_o && resp_err;

endmodule
